// File: rtl/mmio_timer_responder.sv
// mmio_timer_responder
//
// Memory-mapped slave on the core's data-memory req/rsp interface. It sits
// beside the data SRAM behind an address decode and provides:
//   - a 32-bit GPIO output register driving io_pin
//   - a 64-bit prescaled free-running timer (MTIME) with a 64-bit compare
//     register (MTIMECMP) and a level interrupt
//   - a programmable response latency, so the core's wait-state path gets
//     exercised
//
// State table:
//   state   | meaning
//   IDLE    | ready for a request; io_req_ready = 1
//   WAIT    | request accepted, burning LATENCY-1 wait cycles
//   RESP    | io_rsp_valid pulse; read data driven on dataResponse
//
// Register map (offset = addr[7:2] << 2):
//   0x00 GPIO_OUT    RW
//   0x04 MTIME_LO    RW
//   0x08 MTIME_HI    RW
//   0x0C MTIMECMP_LO RW
//   0x10 MTIMECMP_HI RW
//   0x14 CTRL        RW  [0] = EN, [31:1] read 0
//   0x18 STATUS      RO  [0] = PEND
//   other offsets and addresses outside the region: writes ignored, reads 0
//
// Ports:
//   clock                      in   rising-edge clock
//   reset                      in   asynchronous, active-high reset
//   io_req_valid               in   request present, held until accepted
//   io_req_ready               out  high only in IDLE; accept = valid && ready
//   io_req_bits_addrRequest    in   byte address, [1:0] ignored
//   io_req_bits_dataRequest    in   write data
//   io_req_bits_activeByteLane in   write byte enables
//   io_req_bits_isWrite        in   1 = write, 0 = read
//   io_rsp_valid               out  one-cycle response pulse
//   io_rsp_bits_dataResponse   out  read data in RESP, 0 otherwise
//   io_pin                     out  GPIO_OUT register
//   io_irq                     out  timer interrupt, level (PEND && EN)

module mmio_timer_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [31:0] io_req_bits_addrRequest,
  input  logic [31:0] io_req_bits_dataRequest,
  input  logic [3:0]  io_req_bits_activeByteLane,
  input  logic        io_req_bits_isWrite,
  output logic        io_rsp_valid,
  output logic [31:0] io_rsp_bits_dataResponse,
  output logic [31:0] io_pin,
  output logic        io_irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [5:0] IDX_GPIO     = 6'd0;
  localparam logic [5:0] IDX_MTIME_LO = 6'd1;
  localparam logic [5:0] IDX_MTIME_HI = 6'd2;
  localparam logic [5:0] IDX_CMP_LO   = 6'd3;
  localparam logic [5:0] IDX_CMP_HI   = 6'd4;
  localparam logic [5:0] IDX_CTRL     = 6'd5;
  localparam logic [5:0] IDX_STATUS   = 6'd6;

  // The wait counter is loaded on accept and counts down to zero; WAIT lasts
  // LATENCY-1 cycles, so the load value is LATENCY-2 (unused when LATENCY==1).
  localparam logic [3:0]  WAIT_LOAD  = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
  localparam bit          LAT_ONE    = (LATENCY == 1);

  state_t       state_q, state_d;
  logic [3:0]   wait_cnt_q, wait_cnt_d;
  logic [31:0]  rd_data_q, rd_data_d;
  logic [31:0]  gpio_q, gpio_d;
  logic [63:0]  mtime_q, mtime_d;
  logic [63:0]  mtimecmp_q, mtimecmp_d;
  logic         en_q, en_d;
  logic [15:0]  presc_q, presc_d;
  logic         pend_q, pend_d;

  logic         accept;
  logic         region_hit;
  logic [5:0]   reg_idx;
  logic         wr_en;
  logic [31:0]  rd_mux;
  logic         tick;
  logic         addr_lsb_unused;

  assign addr_lsb_unused = ^io_req_bits_addrRequest[1:0];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Address decode and read mux
  always_comb begin
    accept     = io_req_valid && (state_q == ST_IDLE);
    region_hit = (io_req_bits_addrRequest[31:8] == BASE_ADDR[31:8]);
    reg_idx    = io_req_bits_addrRequest[7:2];
    wr_en      = accept && io_req_bits_isWrite && region_hit;

    rd_mux = 32'd0;
    if (region_hit) begin
      case (reg_idx)
        IDX_GPIO:     rd_mux = gpio_q;
        IDX_MTIME_LO: rd_mux = mtime_q[31:0];
        IDX_MTIME_HI: rd_mux = mtime_q[63:32];
        IDX_CMP_LO:   rd_mux = mtimecmp_q[31:0];
        IDX_CMP_HI:   rd_mux = mtimecmp_q[63:32];
        IDX_CTRL:     rd_mux = {31'd0, en_q};
        IDX_STATUS:   rd_mux = {31'd0, pend_q};
        default:      rd_mux = 32'd0;
      endcase
    end
  end

  // Response FSM
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    rd_data_d  = rd_data_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rd_data_d = io_req_bits_isWrite ? 32'd0 : rd_mux;
          if (LAT_ONE) begin
            state_d = ST_RESP;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register writes and timer
  always_comb begin
    gpio_d     = gpio_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;

    tick    = en_q && (presc_q == PRESC_LAST);
    presc_d = 16'd0;
    if (en_q && !tick) presc_d = presc_q + 16'd1;

    mtime_d = tick ? (mtime_q + 64'd1) : mtime_q;

    if (wr_en) begin
      case (reg_idx)
        IDX_GPIO: begin
          gpio_d = merge_bytes(gpio_q, io_req_bits_dataRequest,
                               io_req_bits_activeByteLane);
        end
        // A write to either MTIME half suppresses the tick for that cycle and
        // merges into the pre-tick value.
        IDX_MTIME_LO: begin
          mtime_d = {mtime_q[63:32],
                     merge_bytes(mtime_q[31:0], io_req_bits_dataRequest,
                                 io_req_bits_activeByteLane)};
        end
        IDX_MTIME_HI: begin
          mtime_d = {merge_bytes(mtime_q[63:32], io_req_bits_dataRequest,
                                 io_req_bits_activeByteLane),
                     mtime_q[31:0]};
        end
        IDX_CMP_LO: begin
          mtimecmp_d[31:0] = merge_bytes(mtimecmp_q[31:0], io_req_bits_dataRequest,
                                         io_req_bits_activeByteLane);
        end
        IDX_CMP_HI: begin
          mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], io_req_bits_dataRequest,
                                          io_req_bits_activeByteLane);
        end
        IDX_CTRL: begin
          if (io_req_bits_activeByteLane[0]) en_d = io_req_bits_dataRequest[0];
        end
        default: begin
        end
      endcase
    end

    pend_d = (mtime_q >= mtimecmp_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      rd_data_q  <= 32'd0;
      gpio_q     <= 32'd0;
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_q       <= 1'b0;
      presc_q    <= 16'd0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rd_data_q  <= rd_data_d;
      gpio_q     <= gpio_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      presc_q    <= presc_d;
      pend_q     <= pend_d;
    end
  end

  assign io_req_ready             = (state_q == ST_IDLE);
  assign io_rsp_valid             = (state_q == ST_RESP);
  assign io_rsp_bits_dataResponse = (state_q == ST_RESP) ? rd_data_q : 32'd0;
  assign io_pin                   = gpio_q;
  assign io_irq                   = pend_q && en_q;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Directed bench for mmio_timer_responder. Two instances share the clock:
// index 0 runs LATENCY=1/PRESCALE=1, index 1 runs LATENCY=3/PRESCALE=4.

module tb_mmio_timer_responder;

  logic        clk;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_data  [2];
  logic [3:0]  req_be    [2];
  logic        req_wr    [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_data  [2];
  logic [31:0] pin       [2];
  logic        irq       [2];

  int checks = 0;
  int passed = 0;

  int          lat;
  int          busy;
  int          pulses;
  logic [31:0] rdata;

  mmio_timer_responder #(.BASE_ADDR(32'h4000_0000), .LATENCY(1), .PRESCALE(1)) u_dut_a (
    .clock                      (clk),
    .reset                      (rst[0]),
    .io_req_valid               (req_valid[0]),
    .io_req_ready               (req_ready[0]),
    .io_req_bits_addrRequest    (req_addr[0]),
    .io_req_bits_dataRequest    (req_data[0]),
    .io_req_bits_activeByteLane (req_be[0]),
    .io_req_bits_isWrite        (req_wr[0]),
    .io_rsp_valid               (rsp_valid[0]),
    .io_rsp_bits_dataResponse   (rsp_data[0]),
    .io_pin                     (pin[0]),
    .io_irq                     (irq[0])
  );

  mmio_timer_responder #(.BASE_ADDR(32'h4000_0000), .LATENCY(3), .PRESCALE(4)) u_dut_b (
    .clock                      (clk),
    .reset                      (rst[1]),
    .io_req_valid               (req_valid[1]),
    .io_req_ready               (req_ready[1]),
    .io_req_bits_addrRequest    (req_addr[1]),
    .io_req_bits_dataRequest    (req_data[1]),
    .io_req_bits_activeByteLane (req_be[1]),
    .io_req_bits_isWrite        (req_wr[1]),
    .io_rsp_valid               (rsp_valid[1]),
    .io_rsp_bits_dataResponse   (rsp_data[1]),
    .io_pin                     (pin[1]),
    .io_irq                     (irq[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one request on instance d starting just after a clock edge. Returns
  // the response latency in cycles after the accept edge (0 on timeout), the
  // response data and the number of cycles ready was low while waiting.
  // With hold set, valid stays high until the response cycle.
  task automatic bus_xfer(input int d, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be, input bit hold,
                          output int lat_o, output logic [31:0] rdata_o, output int busy_o);
    bit acc;
    acc     = 1'b0;
    lat_o   = 0;
    rdata_o = 32'd0;
    busy_o  = 0;
    req_valid[d] = 1'b1;
    req_wr[d]    = wr;
    req_addr[d]  = addr;
    req_data[d]  = data;
    req_be[d]    = be;
    for (int i = 0; i < 20 && !acc; i++) begin
      if (req_ready[d]) acc = 1'b1;
      @(posedge clk); #1;
    end
    if (!hold) req_valid[d] = 1'b0;
    if (acc) begin
      for (int i = 1; i <= 20; i++) begin
        if (!req_ready[d]) busy_o++;
        if (rsp_valid[d]) begin
          lat_o   = i;
          rdata_o = rsp_data[d];
          break;
        end
        @(posedge clk); #1;
      end
    end
    req_valid[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic count_rsp(input int d, input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (rsp_valid[d]) n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d]       = 1'b1;
      req_valid[d] = 1'b0;
      req_addr[d]  = 32'd0;
      req_data[d]  = 32'd0;
      req_be[d]    = 4'd0;
      req_wr[d]    = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("reset_ready",     64'(req_ready[0]), 64'd1);
    check("reset_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check("reset_rsp_data",  64'(rsp_data[0]),  64'd0);
    check("reset_pin",       64'(pin[0]),       64'd0);
    check("reset_irq",       64'(irq[0]),       64'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(posedge clk); #1;

    // Compare register reset value, LATENCY=1
    bus_xfer(0, 1'b0, 32'h4000_000C, 32'd0, 4'h0, 1'b0, lat, rdata, busy);
    check("cmp_lo_lat",  64'(lat),   64'd1);
    check("cmp_lo_data", 64'(rdata), 64'hFFFF_FFFF);
    bus_xfer(0, 1'b0, 32'h4000_0010, 32'd0, 4'h0, 1'b0, lat, rdata, busy);
    check("cmp_hi_data", 64'(rdata), 64'hFFFF_FFFF);
    check("t1_pin", 64'(pin[0]), 64'd0);
    check("t1_irq", 64'(irq[0]), 64'd0);

    // GPIO with byte lanes
    bus_xfer(0, 1'b1, 32'h4000_0000, 32'hA5A5_A5A5, 4'hF, 1'b0, lat, rdata, busy);
    check("gpio_full", 64'(pin[0]), 64'hA5A5_A5A5);
    check("wr_rsp_data", 64'(rdata), 64'd0);
    bus_xfer(0, 1'b1, 32'h4000_0000, 32'h0000_3C00, 4'b0010, 1'b0, lat, rdata, busy);
    check("gpio_lane1", 64'(pin[0]), 64'hA5A5_3CA5);
    bus_xfer(0, 1'b1, 32'h4000_0000, 32'hFFFF_FFFF, 4'b0000, 1'b0, lat, rdata, busy);
    check("gpio_be0_noop", 64'(pin[0]), 64'hA5A5_3CA5);
    bus_xfer(0, 1'b0, 32'h4000_0003, 32'd0, 4'h0, 1'b0, lat, rdata, busy);
    check("gpio_readback", 64'(rdata), 64'hA5A5_3CA5);
    check("data_zero_idle", 64'(rsp_data[0]), 64'd0);

    // Unmapped accesses
    bus_xfer(0, 1'b0, 32'h4000_0100, 32'd0, 4'h0, 1'b0, lat, rdata, busy);
    check("outside_lat",  64'(lat),   64'd1);
    check("outside_data", 64'(rdata), 64'd0);
    bus_xfer(0, 1'b0, 32'h4000_001C, 32'd0, 4'h0, 1'b0, lat, rdata, busy);
    check("ofs1c_lat",  64'(lat),   64'd1);
    check("ofs1c_data", 64'(rdata), 64'd0);
    bus_xfer(0, 1'b1, 32'h4000_0100, 32'h0000_0000, 4'hF, 1'b0, lat, rdata, busy);
    check("outside_wr_ignored", 64'(pin[0]), 64'hA5A5_3CA5);

    // 32-bit carry into MTIME_HI with PRESCALE=1
    bus_xfer(0, 1'b1, 32'h4000_0004, 32'hFFFF_FFFF, 4'hF, 1'b0, lat, rdata, busy);
    bus_xfer(0, 1'b1, 32'h4000_0008, 32'h0000_0000, 4'hF, 1'b0, lat, rdata, busy);
    bus_xfer(0, 1'b1, 32'h4000_0014, 32'h0000_0001, 4'hF, 1'b0, lat, rdata, busy);
    bus_xfer(0, 1'b0, 32'h4000_0004, 32'd0, 4'h0, 1'b0, lat, rdata, busy);
    check("carry_lo", 64'(rdata), 64'd0);
    bus_xfer(0, 1'b0, 32'h4000_0008, 32'd0, 4'h0, 1'b0, lat, rdata, busy);
    check("carry_hi", 64'(rdata), 64'd1);
    // Write on a tick cycle: written value stands, one increment per cycle after
    bus_xfer(0, 1'b1, 32'h4000_0004, 32'h0000_1234, 4'hF, 1'b0, lat, rdata, busy);
    bus_xfer(0, 1'b0, 32'h4000_0004, 32'd0, 4'h0, 1'b0, lat, rdata, busy);
    check("tick_write_lo", 64'(rdata), 64'h1235);
    bus_xfer(0, 1'b0, 32'h4000_0008, 32'd0, 4'h0, 1'b0, lat, rdata, busy);
    check("tick_write_hi", 64'(rdata), 64'd1);
    bus_xfer(0, 1'b1, 32'h4000_0004, 32'h0000_00AB, 4'b0001, 1'b0, lat, rdata, busy);
    bus_xfer(0, 1'b0, 32'h4000_0004, 32'd0, 4'h0, 1'b0, lat, rdata, busy);
    check("tick_write_byte", 64'(rdata), 64'h12AC);
    bus_xfer(0, 1'b1, 32'h4000_0014, 32'hFFFF_FFFF, 4'hF, 1'b0, lat, rdata, busy);
    bus_xfer(0, 1'b0, 32'h4000_0014, 32'd0, 4'h0, 1'b0, lat, rdata, busy);
    check("ctrl_upper_zero", 64'(rdata), 64'd1);

    // LATENCY=3 read with valid held during busy
    bus_xfer(1, 1'b0, 32'h4000_0018, 32'd0, 4'h0, 1'b1, lat, rdata, busy);
    check("l3_lat",  64'(lat),   64'd3);
    check("l3_busy", 64'(busy),  64'd3);
    check("l3_data", 64'(rdata), 64'd0);
    count_rsp(1, 8, pulses);
    check("l3_no_double_accept", 64'(pulses), 64'd0);

    // Prescaled timer and compare interrupt (PRESCALE=4)
    bus_xfer(1, 1'b1, 32'h4000_000C, 32'd5, 4'hF, 1'b0, lat, rdata, busy);
    bus_xfer(1, 1'b1, 32'h4000_0010, 32'd0, 4'hF, 1'b0, lat, rdata, busy);
    check("irq_before_en", 64'(irq[1]), 64'd0);
    // EN commits at the accept edge; this call returns 3 edges later.
    bus_xfer(1, 1'b1, 32'h4000_0014, 32'd1, 4'hF, 1'b0, lat, rdata, busy);
    repeat (17) begin
      @(posedge clk); #1;
    end
    check("irq_at_mtime5", 64'(irq[1]), 64'd0);
    @(posedge clk); #1;
    check("irq_rise", 64'(irq[1]), 64'd1);
    bus_xfer(1, 1'b0, 32'h4000_0004, 32'd0, 4'h0, 1'b0, lat, rdata, busy);
    check("mtime_after_20", 64'(rdata), 64'd5);
    bus_xfer(1, 1'b0, 32'h4000_0018, 32'd0, 4'h0, 1'b0, lat, rdata, busy);
    check("status_pend", 64'(rdata), 64'd1);
    bus_xfer(1, 1'b1, 32'h4000_000C, 32'd100, 4'hF, 1'b0, lat, rdata, busy);
    check("irq_fall", 64'(irq[1]), 64'd0);
    bus_xfer(1, 1'b0, 32'h4000_0018, 32'd0, 4'h0, 1'b0, lat, rdata, busy);
    check("status_cleared", 64'(rdata), 64'd0);

    // Reset while in WAIT drops the transaction
    req_valid[1] = 1'b1;
    req_wr[1]    = 1'b0;
    req_addr[1]  = 32'h4000_0000;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    check("in_wait_ready", 64'(req_ready[1]), 64'd0);
    rst[1] = 1'b1;
    #1;
    check("rst_wait_ready", 64'(req_ready[1]), 64'd1);
    check("rst_wait_rsp",   64'(rsp_valid[1]), 64'd0);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    count_rsp(1, 8, pulses);
    check("rst_wait_no_rsp", 64'(pulses), 64'd0);
    check("rst_irq", 64'(irq[1]), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
